// File: rtl/sap_pkg.sv
// Shared constants for the SAP-1 datapath: control-word bit map, idle word and opcodes.
package sap_pkg;

  localparam int unsigned CTRL_W = 15;
  typedef logic [CTRL_W-1:0] ctrl_t;

  localparam int unsigned CB_PC_INC          = 14;
  localparam int unsigned CB_PC_EN           = 13;
  localparam int unsigned CB_PC_LOAD         = 12;
  localparam int unsigned CB_MAR_ADDR_LOAD_N = 11;
  localparam int unsigned CB_MAR_MEM_LOAD_N  = 10;
  localparam int unsigned CB_RAM_EN_N        = 9;
  localparam int unsigned CB_RAM_LOAD_N      = 8;
  localparam int unsigned CB_IR_LOAD_N       = 7;
  localparam int unsigned CB_IR_EN_N         = 6;
  localparam int unsigned CB_REGA_LOAD_N     = 5;
  localparam int unsigned CB_REGA_EN         = 4;
  localparam int unsigned CB_ADDER_SUB       = 3;
  localparam int unsigned CB_REGB_EN         = 2;
  localparam int unsigned CB_REGB_LOAD_N     = 1;
  localparam int unsigned CB_OUT_LOAD_N      = 0;

  // Every active-low strobe high, every active-high strobe low.
  localparam ctrl_t CTRL_IDLE = 15'b000111111100011;

  typedef enum logic [3:0] {
    OP_HLT = 4'h0,
    OP_NOP = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_LDA = 4'h4,
    OP_OUT = 4'h5,
    OP_STA = 4'h6,
    OP_JMP = 4'h7
  } opcode_e;

  function automatic ctrl_t ctrl_bit(int unsigned idx);
    return ctrl_t'(1) << idx;
  endfunction

  // Idle word with the strobes in mask driven to their active level.
  function automatic ctrl_t ctrl_assert(ctrl_t mask);
    return CTRL_IDLE ^ mask;
  endfunction

endpackage

// File: rtl/sap_datapath_if.sv
// Sequencer <-> datapath link: control word towards the datapath, opcode back.
interface sap_datapath_if;
  import sap_pkg::*;

  ctrl_t      ctrl;
  logic [3:0] opcode;

  modport master (output ctrl, input  opcode);
  modport slave  (input  ctrl, output opcode);
endinterface

// File: rtl/sap_ram16x8.sv
// Program/data RAM: asynchronous read, synchronous write, contents not reset.
module sap_ram16x8 #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sap_datapath.sv
// SAP-1 register-transfer datapath on a single shared bus.
// Optional bus contention checker: define SAP_BUS_CHECK_EN.
module sap_datapath
  import sap_pkg::*;
#(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  sap_datapath_if.slave     seq,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] bus,
  output logic              carry,
  output logic              bus_err
);

  ctrl_t ctrl;
  assign ctrl = seq.ctrl;

  logic [ADDR_W-1:0] pc_q, mar_q;
  logic [DATA_W-1:0] mdr_q, ir_q, a_q, b_q, out_q;
  logic              carry_q;

  logic drv_pc, drv_ram, drv_ir, drv_a, drv_alu;
  assign drv_pc  =  ctrl[CB_PC_EN];
  assign drv_ram = ~ctrl[CB_RAM_EN_N];
  assign drv_ir  = ~ctrl[CB_IR_EN_N];
  assign drv_a   =  ctrl[CB_REGA_EN];
  assign drv_alu =  ctrl[CB_REGB_EN];

  // RAM write port belongs to the program loader while in reset, to MDR otherwise.
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  assign ram_we    = rst ? prog_we   : ~ctrl[CB_RAM_LOAD_N];
  assign ram_waddr = rst ? prog_addr : mar_q;
  assign ram_wdata = rst ? prog_data : mdr_q;

  sap_ram16x8 #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (mar_q),
    .rdata (ram_rdata)
  );

  // Subtraction as A + ~B + 1, so the top bit is carry / no-borrow.
  logic [DATA_W-1:0] b_op;
  logic [DATA_W:0]   alu_sum;
  assign b_op    = ctrl[CB_ADDER_SUB] ? ~b_q : b_q;
  assign alu_sum = {1'b0, a_q} + {1'b0, b_op} + {{DATA_W{1'b0}}, ctrl[CB_ADDER_SUB]};

  logic alu_sel;

  always_comb begin
    bus     = '0;
    alu_sel = 1'b0;
    if (drv_pc) begin
      bus = DATA_W'(pc_q);
    end else if (drv_ram) begin
      bus = ram_rdata;
    end else if (drv_ir) begin
      bus = DATA_W'(ir_q[3:0]);
    end else if (drv_a) begin
      bus = a_q;
    end else if (drv_alu) begin
      bus     = alu_sum[DATA_W-1:0];
      alu_sel = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      mar_q   <= '0;
      mdr_q   <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      if (!ctrl[CB_MAR_ADDR_LOAD_N]) mar_q <= bus[ADDR_W-1:0];
      if (!ctrl[CB_MAR_MEM_LOAD_N])  mdr_q <= bus;
      if (!ctrl[CB_IR_LOAD_N])       ir_q  <= bus;
      if (!ctrl[CB_REGA_LOAD_N])     a_q   <= bus;
      if (!ctrl[CB_REGB_LOAD_N])     b_q   <= bus;
      if (!ctrl[CB_OUT_LOAD_N])      out_q <= bus;
      if (!ctrl[CB_REGA_LOAD_N] && alu_sel) carry_q <= alu_sum[DATA_W];
      if (ctrl[CB_PC_LOAD]) begin
        pc_q <= bus[ADDR_W-1:0];
      end else if (ctrl[CB_PC_INC]) begin
        pc_q <= pc_q + ADDR_W'(1);
      end
    end
  end

`ifdef SAP_BUS_CHECK_EN
  logic [4:0] drv;
  logic       multi_drv;
  logic       bus_err_q;

  // Clearing the lowest set bit leaves something only when two or more drivers are on.
  assign drv       = {drv_pc, drv_ram, drv_ir, drv_a, drv_alu};
  assign multi_drv = (drv & (drv - 5'd1)) != '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_err_q <= 1'b0;
    end else if (multi_drv) begin
      bus_err_q <= 1'b1;
    end
  end

  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  assign seq.opcode = ir_q[7:4];
  assign out_data   = out_q;
  assign pc         = pc_q;
  assign carry      = carry_q;

endmodule
